fe_twm64_serial: RTL
====================

Name: fe_twm64_serial

Overview:
- Twiddle multiplier between the two serial BF8 stages of the 64-point BF64 pipeline (BF8 -> TWM -> BF8).
- Consumes the two-lane complex stream produced by the first BF8 and multiplies each sample by W64^e.
- Selects e from an internal frame-position counter.
- Rounds and saturates to the width expected by the second BF8.

Parameters:
- NBW_IN, 11, input word width (two's complement).
- NBI_IN, 4, input integer bits (fractional bits = NBW_IN-NBI_IN).
- NBW_TW, 10, twiddle coefficient width.
- NBI_TW, 2, twiddle integer bits; coefficient scale 2^(NBW_TW-NBI_TW).
- NBW_OUT, 12, output word width.
- NBI_OUT, 5, output integer bits.
- INV, 0, 0 = FFT (W=exp(-j2πe/64)); 1 = IFFT (W=exp(+j2πe/64)).

Ports:
- clk, input, 1, clock.
- rst_async_n, input, 1, reset, asynchronous, active-low.
- i_valid, input, 1, i_data carries two valid complex samples this cycle.
- i_sof, input, 1, qualified by i_valid; this beat is beat 0 of a frame.
- i_data, input, signed NBW_IN x [1:0][1:0], [lane][I=0,Q=1].
- o_valid, output, 1, o_data valid.
- o_data, output, signed NBW_OUT x [1:0][1:0], twiddled samples, same lane/IQ ordering.

Behaviour:
- Frame
  - 64 samples = 32 beats, two samples per beat.
  - 5-bit beat counter cnt advances only on i_valid and wraps 31->0.
  - i_valid && i_sof forces the current beat to be treated as cnt=0; the counter becomes 1 next cycle.
  - i_sof without i_valid is ignored.
- Twiddle index
  - Lane l at beat cnt carries sample index s = 2*cnt + l.
  - m = s[5:3]; p = bitrev3(s[2:0]); e = (m*p) mod 64.
- Coefficients
  - c = round(cos(2πe/64) * 2^(NBW_TW-NBI_TW)); sn = round(sin(2πe/64) * 2^(NBW_TW-NBI_TW)).
  - Generated as constant tables (elaboration-time function or case ROM).
  - Default NBW_TW gives scale 256: e=0 -> (256,0); e=8 -> (181,181); e=16 -> (0,256).
- Multiply, FFT (INV=0)
  - re = I*c + Q*sn
  - im = Q*c - I*sn
- Multiply, IFFT (INV=1)
  - re = I*c - Q*sn
  - im = Q*c + I*sn
- Width and rounding
  - Full-precision products; sum has one extra bit.
  - Drop (NBW_IN-NBI_IN + NBW_TW-NBI_TW) - (NBW_OUT-NBI_OUT) LSBs with round half-up: add 2^(k-1), then arithmetic shift.
  - Saturate to [-2^(NBW_OUT-1), 2^(NBW_OUT-1)-1].
- Pipeline, fixed latency 3 cycles i_valid -> o_valid, no backpressure, full throughput, bubbles preserved.
  - S1: register data, register coefficient index.
  - S2: register four products per lane.
  - S3: add/sub, round, saturate, register output.
- Hold
  - Pipeline data registers load only when their stage valid is high; otherwise they hold.
  - o_data therefore holds its last value while o_valid = 0.
- Reset
  - Mid-operation reset aborts in-flight samples.
  - o_valid = 0, o_data = 0, cnt = 0, all stage valids = 0.
  - First valid beat after reset is beat 0 regardless of i_sof.

Test Plan:
- e=0 passthrough: reset, 32 beats with i_sof on beat 0; beat 0 lane 0 (I,Q)=(100,-37) -> o_data[0] = (100,-37) exactly 3 cycles later (frac bits equal at defaults).
- -j rotation: beat 16 lane 1 (s=33, e=16), FFT, input (100,0) -> (0,-100); same input with INV=1 -> (0,100).
- e=8 rounding: beat 8 lane 1 (s=17), input (128,0), FFT -> (91,-90), half-up on ±90.5.
- Saturation: NBW_OUT=11, NBI_OUT=4, beat 8 lane 1, input (1023,1023) -> re=1447 saturates to 1023, im=0.
- Gaps and resync:
  - Random i_valid bubbles over 3 frames -> o_valid is i_valid delayed 3, and outputs match a reference model indexed by the valid-beat count.
  - i_sof asserted mid-frame at beat 12 restarts indexing (that beat uses e for cnt=0).
- Reset mid-frame: assert rst_async_n low at beat 20 with data in flight -> o_valid drops immediately, o_data=0, and the next valid beat uses cnt=0.

Source files
------------

// File: rtl/fe_twm64_serial.sv
// fe_twm64_serial: twiddle multiplier between the two serial BF8 stages of
// the 64-point pipeline. Each beat carries two complex samples. Sample s is
// multiplied by W64^e, where e = (s[5:3] * bitrev3(s[2:0])) mod 64. The
// result is rounded half-up and saturated. Latency is a fixed 3 cycles.
module fe_twm64_serial #(
  parameter int NBW_IN  = 11,
  parameter int NBI_IN  = 4,
  parameter int NBW_TW  = 10,
  parameter int NBI_TW  = 2,
  parameter int NBW_OUT = 12,
  parameter int NBI_OUT = 5,
  parameter int INV     = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_async_n,
  input  logic                                 i_valid,
  input  logic                                 i_sof,
  input  logic signed [1:0][1:0][NBW_IN-1:0]   i_data,
  output logic                                 o_valid,
  output logic signed [1:0][1:0][NBW_OUT-1:0]  o_data
);

  localparam int FRAC_IN  = NBW_IN - NBI_IN;
  localparam int FRAC_TW  = NBW_TW - NBI_TW;
  localparam int FRAC_OUT = NBW_OUT - NBI_OUT;
  localparam int SHIFT    = FRAC_IN + FRAC_TW - FRAC_OUT;
  localparam int NBW_PROD = NBW_IN + NBW_TW;
  localparam int NBW_SUM  = NBW_PROD + 2;
  localparam int CW       = 2 * NBW_TW;

  // Q30 fixed point is used to build the coefficient tables at elaboration
  localparam int     QF   = 30;
  localparam longint PI_Q = 64'sd3373259426;

  localparam logic signed [NBW_SUM-1:0] RND  = NBW_SUM'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [NBW_SUM-1:0] MAXV = NBW_SUM'((64'sd1 <<< (NBW_OUT - 1)) - 64'sd1);
  localparam logic signed [NBW_SUM-1:0] MINV = NBW_SUM'(-(64'sd1 <<< (NBW_OUT - 1)));

  // sin(r*pi/32) in Q30 for r in 0..16, Taylor series on the first quadrant
  function automatic longint sin_q(input int r);
    longint x, x2, term, acc;
    x    = (PI_Q * r) / 32;
    x2   = (x * x) >>> QF;
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -((term * x2) >>> QF) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // cos(r*pi/32) in Q30 for r in 0..16
  function automatic longint cos_q(input int r);
    longint x, x2, term, acc;
    x    = (PI_Q * r) / 32;
    x2   = (x * x) >>> QF;
    term = 64'sd1 <<< QF;
    acc  = term;
    for (int k = 1; k < 12; k++) begin
      term = -((term * x2) >>> QF) / longint'((2 * k - 1) * (2 * k));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Q30 value rounded half-up to the twiddle format
  function automatic logic [NBW_TW-1:0] to_tw(input longint v);
    longint r;
    r = (v + (64'sd1 <<< (QF - FRAC_TW - 1))) >>> (QF - FRAC_TW);
    return NBW_TW'(r);
  endfunction

  // Full table of {cos, sin} for e = 0..63 using quadrant symmetry
  function automatic logic [64*CW-1:0] build_rom();
    logic [64*CW-1:0] rom;
    longint sa, ca, cq, sq;
    rom = '0;
    for (int idx = 0; idx < 64; idx++) begin
      sa = sin_q(idx % 16);
      ca = cos_q(idx % 16);
      case (idx / 16)
        0:       begin cq =  ca; sq =  sa; end
        1:       begin cq = -sa; sq =  ca; end
        2:       begin cq = -ca; sq = -sa; end
        default: begin cq =  sa; sq = -ca; end
      endcase
      rom[idx*CW +: CW] = {to_tw(cq), to_tw(sq)};
    end
    return rom;
  endfunction

  localparam logic [64*CW-1:0] TW_ROM = build_rom();

  // Add the half LSB, shift arithmetically, then clamp to the output range
  function automatic logic signed [NBW_OUT-1:0] rnd_sat(input logic signed [NBW_SUM-1:0] x);
    logic signed [NBW_SUM-1:0] y;
    y = (x + RND) >>> SHIFT;
    if (y > MAXV)      y = MAXV;
    else if (y < MINV) y = MINV;
    return NBW_OUT'(y);
  endfunction

  logic [4:0]                        cnt;
  logic [4:0]                        beat;
  logic [1:0][5:0]                   sidx;
  logic [1:0][5:0]                   e_next;
  logic                              v1, v2;
  logic signed [1:0][1:0][NBW_IN-1:0] s1_data;
  logic [1:0][5:0]                   s1_e;
  logic signed [NBW_TW-1:0]          coef_c [2];
  logic signed [NBW_TW-1:0]          coef_s [2];
  logic signed [NBW_PROD-1:0]        prod [2][4];
  logic signed [NBW_SUM-1:0]         sum_re [2];
  logic signed [NBW_SUM-1:0]         sum_im [2];
  logic signed [1:0][1:0][NBW_OUT-1:0] o_next;

  // A valid sof beat is beat 0; both lanes derive their twiddle exponent here
  always_comb begin
    beat = i_sof ? 5'd0 : cnt;
    for (int l = 0; l < 2; l++) begin
      sidx[l]   = {beat, l[0]};
      e_next[l] = {3'b000, sidx[l][5:3]} * {3'b000, sidx[l][0], sidx[l][1], sidx[l][2]};
    end
  end

  // Beat counter advances on valid beats only and wraps naturally at 32
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) cnt <= '0;
    else if (i_valid) cnt <= beat + 5'd1;
  end

  // Stage valid chain; bubbles travel with the data
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      v1      <= i_valid;
      v2      <= v1;
      o_valid <= v2;
    end
  end

  // S1: capture samples and their twiddle exponents
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      s1_data <= '0;
      s1_e    <= '0;
    end else if (i_valid) begin
      s1_data <= i_data;
      s1_e    <= e_next;
    end
  end

  // Coefficient lookup from the elaboration-time table
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      coef_c[l] = $signed(TW_ROM[int'(s1_e[l])*CW + NBW_TW +: NBW_TW]);
      coef_s[l] = $signed(TW_ROM[int'(s1_e[l])*CW +: NBW_TW]);
    end
  end

  // S2: four full-precision products per lane (I*c, Q*s, Q*c, I*s)
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      for (int l = 0; l < 2; l++)
        for (int k = 0; k < 4; k++)
          prod[l][k] <= '0;
    end else if (v1) begin
      for (int l = 0; l < 2; l++) begin
        prod[l][0] <= NBW_PROD'($signed(s1_data[l][0])) * NBW_PROD'(coef_c[l]);
        prod[l][1] <= NBW_PROD'($signed(s1_data[l][1])) * NBW_PROD'(coef_s[l]);
        prod[l][2] <= NBW_PROD'($signed(s1_data[l][1])) * NBW_PROD'(coef_c[l]);
        prod[l][3] <= NBW_PROD'($signed(s1_data[l][0])) * NBW_PROD'(coef_s[l]);
      end
    end
  end

  // Combine products with the rotation direction, then round and saturate
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      if (INV == 0) begin
        sum_re[l] = NBW_SUM'(prod[l][0]) + NBW_SUM'(prod[l][1]);
        sum_im[l] = NBW_SUM'(prod[l][2]) - NBW_SUM'(prod[l][3]);
      end else begin
        sum_re[l] = NBW_SUM'(prod[l][0]) - NBW_SUM'(prod[l][1]);
        sum_im[l] = NBW_SUM'(prod[l][2]) + NBW_SUM'(prod[l][3]);
      end
      o_next[l][0] = rnd_sat(sum_re[l]);
      o_next[l][1] = rnd_sat(sum_im[l]);
    end
  end

  // S3: output register holds its value through bubbles
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) o_data <= '0;
    else if (v2)      o_data <= o_next;
  end

endmodule
